// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: datapath widths,
// ALU op encodings and result-select codes.
package id_ex_stage_pkg;

    localparam int XLEN = 32;
    localparam int RFAW = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101,
        ALU_SLL = 3'b110,
        ALU_SRL = 3'b111
    } alu_op_e;

    localparam logic [1:0] RESULTSRC_ALU  = 2'b00;
    localparam logic [1:0] RESULTSRC_LOAD = 2'b01;
    localparam logic [1:0] RESULTSRC_PC4  = 2'b10;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand bypass for one E-stage source register: MEM result first, then WB
// result, else the value read from the register file. x0 is never bypassed.
module fwd_mux #(
    parameter int XLEN = 32,
    parameter int RFAW = 5
) (
    input  logic [RFAW-1:0] rs,
    input  logic [XLEN-1:0] regval,
    input  logic [RFAW-1:0] rd_m,
    input  logic            regwrite_m,
    input  logic [XLEN-1:0] aluresult_m,
    input  logic [RFAW-1:0] rd_w,
    input  logic            regwrite_w,
    input  logic [XLEN-1:0] result_w,
    output logic [XLEN-1:0] fwd_val
);

    logic hit_m_s;
    logic hit_w_s;

    assign hit_m_s = regwrite_m && (rd_m == rs) && (rd_m != {RFAW{1'b0}});
    assign hit_w_s = regwrite_w && (rd_w == rs) && (rd_w != {RFAW{1'b0}});

    // Priority select: the younger MEM result shadows the older WB result
    always_comb begin
        fwd_val = regval;
        if (hit_m_s) begin
            fwd_val = aluresult_m;
        end else if (hit_w_s) begin
            fwd_val = result_w;
        end else begin
            fwd_val = regval;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use
// hazard detection, feeding the ALU directly.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int XLEN = id_ex_stage_pkg::XLEN,
    parameter int RFAW = id_ex_stage_pkg::RFAW
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall_e,
    input  logic            flush_e,
    input  logic            valid_d,
    input  logic [XLEN-1:0] rd1_d,
    input  logic [XLEN-1:0] rd2_d,
    input  logic [XLEN-1:0] imm_d,
    input  logic [XLEN-1:0] pc_d,
    input  logic [XLEN-1:0] pcplus4_d,
    input  logic [RFAW-1:0] rs1_d,
    input  logic [RFAW-1:0] rs2_d,
    input  logic [RFAW-1:0] rd_d,
    input  logic [2:0]      alucontrol_d,
    input  logic            alusrc_d,
    input  logic            regwrite_d,
    input  logic            memwrite_d,
    input  logic            branch_d,
    input  logic            jump_d,
    input  logic [1:0]      resultsrc_d,
    input  logic [RFAW-1:0] rd_m,
    input  logic            regwrite_m,
    input  logic [XLEN-1:0] aluresult_m,
    input  logic [RFAW-1:0] rd_w,
    input  logic            regwrite_w,
    input  logic [XLEN-1:0] result_w,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [2:0]      alucontrol_e,
    output logic [XLEN-1:0] writedata_e,
    output logic [XLEN-1:0] pc_e,
    output logic [XLEN-1:0] pcplus4_e,
    output logic [XLEN-1:0] imm_e,
    output logic [RFAW-1:0] rd_e,
    output logic            valid_e,
    output logic            regwrite_e,
    output logic            memwrite_e,
    output logic            branch_e,
    output logic            jump_e,
    output logic [1:0]      resultsrc_e,
    output logic            loaduse_stall
);

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memwrite;
        logic            branch;
        logic            jump;
        logic [1:0]      resultsrc;
        logic            alusrc;
        logic [2:0]      alucontrol;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcplus4;
        logic [RFAW-1:0] rs1;
        logic [RFAW-1:0] rs2;
        logic [RFAW-1:0] rd;
    } ex_slot_t;

    ex_slot_t        ex_q;
    ex_slot_t        ex_d;
    logic [XLEN-1:0] fwd_a_s;
    logic [XLEN-1:0] fwd_b_s;

    // Next E-slot contents: flush beats stall, stall beats capture
    always_comb begin
        ex_d = ex_q;
        if (flush_e) begin
            ex_d = '0;
        end else if (stall_e) begin
            ex_d = ex_q;
        end else begin
            // An empty D slot enters E as a bubble whose controls cannot fire
            ex_d.valid      = valid_d;
            ex_d.regwrite   = valid_d & regwrite_d;
            ex_d.memwrite   = valid_d & memwrite_d;
            ex_d.branch     = valid_d & branch_d;
            ex_d.jump       = valid_d & jump_d;
            ex_d.resultsrc  = valid_d ? resultsrc_d : RESULTSRC_ALU;
            ex_d.alusrc     = alusrc_d;
            ex_d.alucontrol = alucontrol_d;
            ex_d.rd1        = rd1_d;
            ex_d.rd2        = rd2_d;
            ex_d.imm        = imm_d;
            ex_d.pc         = pc_d;
            ex_d.pcplus4    = pcplus4_d;
            ex_d.rs1        = rs1_d;
            ex_d.rs2        = rs2_d;
            ex_d.rd         = rd_d;
        end
    end

    // E-slot storage; reset empties the slot immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    fwd_mux #(.XLEN(XLEN), .RFAW(RFAW)) u_fwd_a (
        .rs          (ex_q.rs1),
        .regval      (ex_q.rd1),
        .rd_m        (rd_m),
        .regwrite_m  (regwrite_m),
        .aluresult_m (aluresult_m),
        .rd_w        (rd_w),
        .regwrite_w  (regwrite_w),
        .result_w    (result_w),
        .fwd_val     (fwd_a_s)
    );

    fwd_mux #(.XLEN(XLEN), .RFAW(RFAW)) u_fwd_b (
        .rs          (ex_q.rs2),
        .regval      (ex_q.rd2),
        .rd_m        (rd_m),
        .regwrite_m  (regwrite_m),
        .aluresult_m (aluresult_m),
        .rd_w        (rd_w),
        .regwrite_w  (regwrite_w),
        .result_w    (result_w),
        .fwd_val     (fwd_b_s)
    );

    assign alu_a        = fwd_a_s;
    assign writedata_e  = fwd_b_s;
    assign alu_b        = ex_q.alusrc ? ex_q.imm : fwd_b_s;
    assign alucontrol_e = ex_q.alucontrol;
    assign pc_e         = ex_q.pc;
    assign pcplus4_e    = ex_q.pcplus4;
    assign imm_e        = ex_q.imm;
    assign rd_e         = ex_q.rd;
    assign valid_e      = ex_q.valid;
    assign regwrite_e   = ex_q.regwrite;
    assign memwrite_e   = ex_q.memwrite;
    assign branch_e     = ex_q.branch;
    assign jump_e       = ex_q.jump;
    assign resultsrc_e  = ex_q.resultsrc;

    // A load in E cannot supply its data to the instruction now in D
    assign loaduse_stall = ex_q.valid && (ex_q.resultsrc == RESULTSRC_LOAD) &&
                           (ex_q.rd != {RFAW{1'b0}}) && valid_d &&
                           ((ex_q.rd == rs1_d) || (ex_q.rd == rs2_d));

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic, all compared against a behavioural model of the E slot.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n, stall_e, flush_e, valid_d;
    logic [31:0] rd1_d, rd2_d, imm_d, pc_d, pcplus4_d;
    logic [4:0]  rs1_d, rs2_d, rd_d;
    logic [2:0]  alucontrol_d;
    logic        alusrc_d, regwrite_d, memwrite_d, branch_d, jump_d;
    logic [1:0]  resultsrc_d;
    logic [4:0]  rd_m, rd_w;
    logic        regwrite_m, regwrite_w;
    logic [31:0] aluresult_m, result_w;
    logic [31:0] alu_a, alu_b, writedata_e, pc_e, pcplus4_e, imm_e;
    logic [2:0]  alucontrol_e;
    logic [4:0]  rd_e;
    logic        valid_e, regwrite_e, memwrite_e, branch_e, jump_e;
    logic [1:0]  resultsrc_e;
    logic        loaduse_stall;

    int checks = 0;
    int errors = 0;

    // Reference E-slot contents, kept as plain variables
    logic        m_valid, m_rw, m_mw, m_br, m_j, m_asrc;
    logic [1:0]  m_rsrc;
    logic [2:0]  m_aluc;
    logic [31:0] m_rd1, m_rd2, m_imm, m_pc, m_pc4;
    logic [4:0]  m_rs1, m_rs2, m_rd;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .reset_n(reset_n), .stall_e(stall_e), .flush_e(flush_e),
        .valid_d(valid_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d),
        .pc_d(pc_d), .pcplus4_d(pcplus4_d), .rs1_d(rs1_d), .rs2_d(rs2_d),
        .rd_d(rd_d), .alucontrol_d(alucontrol_d), .alusrc_d(alusrc_d),
        .regwrite_d(regwrite_d), .memwrite_d(memwrite_d), .branch_d(branch_d),
        .jump_d(jump_d), .resultsrc_d(resultsrc_d), .rd_m(rd_m),
        .regwrite_m(regwrite_m), .aluresult_m(aluresult_m), .rd_w(rd_w),
        .regwrite_w(regwrite_w), .result_w(result_w), .alu_a(alu_a),
        .alu_b(alu_b), .alucontrol_e(alucontrol_e), .writedata_e(writedata_e),
        .pc_e(pc_e), .pcplus4_e(pcplus4_e), .imm_e(imm_e), .rd_e(rd_e),
        .valid_e(valid_e), .regwrite_e(regwrite_e), .memwrite_e(memwrite_e),
        .branch_e(branch_e), .jump_e(jump_e), .resultsrc_e(resultsrc_e),
        .loaduse_stall(loaduse_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        {m_valid, m_rw, m_mw, m_br, m_j, m_asrc} = 6'b0;
        m_rsrc = 2'b0; m_aluc = 3'b0;
        m_rd1 = 32'h0; m_rd2 = 32'h0; m_imm = 32'h0; m_pc = 32'h0; m_pc4 = 32'h0;
        m_rs1 = 5'h0; m_rs2 = 5'h0; m_rd = 5'h0;
    endtask

    task automatic model_clock();
        if (!reset_n || flush_e) begin
            model_reset();
        end else if (!stall_e) begin
            m_valid = valid_d;
            m_rw = valid_d && regwrite_d;
            m_mw = valid_d && memwrite_d;
            m_br = valid_d && branch_d;
            m_j  = valid_d && jump_d;
            m_rsrc = valid_d ? resultsrc_d : 2'b00;
            m_asrc = alusrc_d; m_aluc = alucontrol_d;
            m_rd1 = rd1_d; m_rd2 = rd2_d; m_imm = imm_d; m_pc = pc_d; m_pc4 = pcplus4_d;
            m_rs1 = rs1_d; m_rs2 = rs2_d; m_rd = rd_d;
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] regval);
        if (regwrite_m && rd_m == rs && rd_m != 5'd0) return aluresult_m;
        if (regwrite_w && rd_w == rs && rd_w != 5'd0) return result_w;
        return regval;
    endfunction

    task automatic check_all();
        logic [31:0] wd;
        logic        lu;
        wd = fwd(m_rs2, m_rd2);
        lu = m_valid && m_rsrc == 2'b01 && m_rd != 5'd0 && valid_d &&
             (m_rd == rs1_d || m_rd == rs2_d);
        chk("alu_a", alu_a, fwd(m_rs1, m_rd1));
        chk("writedata_e", writedata_e, wd);
        chk("alu_b", alu_b, m_asrc ? m_imm : wd);
        chk("alucontrol_e", 32'(alucontrol_e), 32'(m_aluc));
        chk("pc_e", pc_e, m_pc);
        chk("pcplus4_e", pcplus4_e, m_pc4);
        chk("imm_e", imm_e, m_imm);
        chk("rd_e", 32'(rd_e), 32'(m_rd));
        chk("ctrl", 32'({valid_e, regwrite_e, memwrite_e, branch_e, jump_e, resultsrc_e}),
            32'({m_valid, m_rw, m_mw, m_br, m_j, m_rsrc}));
        chk("loaduse_stall", 32'(loaduse_stall), 32'(lu));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_clock();
        @(negedge clk);
        check_all();
    endtask

    task automatic clr_inputs();
        {stall_e, flush_e, valid_d, alusrc_d, regwrite_d, memwrite_d, branch_d, jump_d} = 8'b0;
        rd1_d = 32'h0; rd2_d = 32'h0; imm_d = 32'h0; pc_d = 32'h0; pcplus4_d = 32'h0;
        rs1_d = 5'h0; rs2_d = 5'h0; rd_d = 5'h0; alucontrol_d = 3'b0; resultsrc_d = 2'b0;
        rd_m = 5'h0; rd_w = 5'h0; regwrite_m = 1'b0; regwrite_w = 1'b0;
        aluresult_m = 32'h0; result_w = 32'h0;
    endtask

    task automatic rand_inputs();
        stall_e = ($urandom_range(0, 7) == 0);
        flush_e = ($urandom_range(0, 9) == 0);
        valid_d = ($urandom_range(0, 3) != 0);
        rd1_d = $urandom; rd2_d = $urandom; imm_d = $urandom;
        pc_d = $urandom; pcplus4_d = $urandom;
        rs1_d = 5'($urandom_range(0, 7)); rs2_d = 5'($urandom_range(0, 7));
        rd_d = 5'($urandom_range(0, 7));
        alucontrol_d = 3'($urandom); alusrc_d = 1'($urandom);
        regwrite_d = 1'($urandom); memwrite_d = 1'($urandom);
        branch_d = 1'($urandom); jump_d = 1'($urandom);
        resultsrc_d = 2'($urandom_range(0, 2));
        rd_m = 5'($urandom_range(0, 7)); rd_w = 5'($urandom_range(0, 7));
        regwrite_m = 1'($urandom); regwrite_w = 1'($urandom);
        aluresult_m = $urandom; result_w = $urandom;
    endtask

    initial begin
        clr_inputs();
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        check_all();
        @(negedge clk);
        reset_n = 1'b1;

        // Plain capture of add x3, x1, x2
        valid_d = 1'b1; rd1_d = 32'd5; rd2_d = 32'd7; rs1_d = 5'd1; rs2_d = 5'd2;
        rd_d = 5'd3; regwrite_d = 1'b1; alucontrol_d = 3'b000; pc_d = 32'h100;
        cycle();
        chk("cap_alu_a", alu_a, 32'd5);
        chk("cap_alu_b", alu_b, 32'd7);
        chk("cap_valid", 32'(valid_e), 32'd1);

        // Asynchronous reset while add x3 is in E
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_valid", 32'(valid_e), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Forwarding priority MEM over WB, and x0 never forwarded
        clr_inputs();
        valid_d = 1'b1; rs1_d = 5'd4; rd1_d = 32'h55;
        cycle();
        rd_m = 5'd4; aluresult_m = 32'h11; regwrite_m = 1'b1;
        rd_w = 5'd4; result_w = 32'h22; regwrite_w = 1'b1;
        #1 chk("fwd_mem", alu_a, 32'h11);
        regwrite_m = 1'b0;
        #1 chk("fwd_wb", alu_a, 32'h22);
        rs1_d = 5'd0; rd1_d = 32'h66; rd_m = 5'd0; rd_w = 5'd0;
        regwrite_m = 1'b1; regwrite_w = 1'b1;
        cycle();
        chk("fwd_x0", alu_a, 32'h66);

        // Immediate select with rs2 still forwarded to store data
        clr_inputs();
        valid_d = 1'b1; alusrc_d = 1'b1; imm_d = 32'hFFFF_FFF0; rs2_d = 5'd6; rd2_d = 32'h77;
        cycle();
        rd_m = 5'd6; regwrite_m = 1'b1; aluresult_m = 32'h9;
        #1 chk("imm_alu_b", alu_b, 32'hFFFF_FFF0);
        chk("imm_wdata", writedata_e, 32'h9);

        // Load-use against lw x5, then against a load targeting x0
        clr_inputs();
        valid_d = 1'b1; rd_d = 5'd5; resultsrc_d = RESULTSRC_LOAD; regwrite_d = 1'b1;
        cycle();
        rd_d = 5'd0; rs1_d = 5'd0; rs2_d = 5'd5;
        #1 chk("lu_hit", 32'(loaduse_stall), 32'd1);
        cycle();
        rs2_d = 5'd0;
        #1 chk("lu_x0", 32'(loaduse_stall), 32'd0);

        // Stall holds E across changing D; flush wins over stall
        clr_inputs();
        valid_d = 1'b1; pc_d = 32'hABC0; regwrite_d = 1'b1; memwrite_d = 1'b1;
        cycle();
        stall_e = 1'b1; pc_d = 32'h1234; valid_d = 1'b0;
        cycle();
        pc_d = 32'h5678;
        cycle();
        chk("stall_pc", pc_e, 32'hABC0);
        chk("stall_valid", 32'(valid_e), 32'd1);
        flush_e = 1'b1;
        cycle();
        chk("flush_ctrl", 32'({valid_e, regwrite_e, memwrite_e}), 32'd0);

        for (int i = 0; i < 600; i++) begin
            rand_inputs();
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
